// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: issues multiplies to an external registered multiplier and runs a
// 32-step restoring divider. Define MULDIV_DIV_EARLY_OUT_EN to finish divides with |a| < |b| at once.
module muldiv_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [RD_W-1:0] op_rd,
    output logic [3:0]      mul_sel,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] mul_res,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [RD_W-1:0] res_rd,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_RUN,
        DIV_FIX,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            rem_sel_q, rem_sel_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;

    logic            is_signed;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            b_zero, ovf;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fix, r_fix;

    assign is_signed = ~op_funct[0];
    assign a_mag     = (is_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign b_mag     = (is_signed && op_b[XLEN-1]) ? -op_b : op_b;
    assign b_zero    = (op_b == '0);
    assign ovf       = is_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

    // Partial remainder stays below the divisor, so XLEN+1 bits capture the borrow exactly.
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    assign q_fix = negq_q ? -quo_q : quo_q;
    assign r_fix = negr_q ? -rem_q : rem_q;

    assign res_valid = (state_q == DONE);
    assign res_data  = data_q;
    assign res_rd    = rd_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        rd_d      = rd_q;
        data_d    = data_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        op_ready  = (state_q == IDLE) && !flush;
        mul_sel   = '0;
        mul_a     = op_a;
        mul_b     = op_b;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        rem_sel_d = op_funct[1];
                        rd_d      = op_rd;
                        if (!op_funct[2]) begin
                            mul_sel = {1'b0, op_funct} + 4'd1;
                            state_d = MUL_WAIT;
                        end else if (b_zero) begin
                            data_d  = op_funct[1] ? op_a : '1;
                            state_d = DONE;
                        end else if (ovf) begin
                            data_d  = op_funct[1] ? '0 : op_a;
                            state_d = DONE;
`ifdef MULDIV_DIV_EARLY_OUT_EN
                        end else if (a_mag < b_mag) begin
                            data_d  = op_funct[1] ? op_a : '0;
                            state_d = DONE;
`endif
                        end else begin
                            quo_d   = a_mag;
                            rem_d   = '0;
                            dvs_d   = b_mag;
                            cnt_d   = 6'd31;
                            negq_d  = is_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                            negr_d  = is_signed && op_a[XLEN-1];
                            state_d = DIV_RUN;
                        end
                    end
                end
                MUL_WAIT: begin
                    data_d  = mul_res;
                    state_d = DONE;
                end
                DIV_RUN: begin
                    if (!trial[XLEN]) begin
                        rem_d = trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == '0) state_d = DIV_FIX;
                    else             cnt_d   = cnt_q - 6'd1;
                end
                DIV_FIX: begin
                    data_d  = rem_sel_q ? r_fix : q_fix;
                    state_d = DONE;
                end
                DONE: begin
                    if (res_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            rem_sel_q <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural registered multiplier on the mul_* port.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_funct;
    logic [31:0] op_a, op_b;
    logic [4:0]  op_rd;
    logic [3:0]  mul_sel;
    logic [31:0] mul_a, mul_b;
    logic [31:0] mul_res = '0;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .op_valid(op_valid), .op_ready(op_ready), .op_funct(op_funct),
        .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
        .mul_sel(mul_sel), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .busy(busy)
    );

    function automatic logic [31:0] mul_model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, za, zb, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        za = {32'b0, a};
        zb = {32'b0, b};
        case (s)
            4'd2:    p = sa * sb;
            4'd3:    p = sa * zb;
            default: p = za * zb;
        endcase
        return (s == 4'd1) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk) if (mul_sel != 4'd0) mul_res <= mul_model(mul_sel, mul_a, mul_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input int hold);
        int lat;
        op_valid = 1'b1; op_funct = f; op_a = a; op_b = b; op_rd = rd;
        #1;
        chk($sformatf("%s.rdy", tag), 32'(op_ready), 32'd1);
        chk($sformatf("%s.sel", tag), 32'(mul_sel), f[2] ? 32'd0 : 32'(f) + 32'd1);
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        chk($sformatf("%s.sel0", tag), 32'(mul_sel), 32'd0);
        chk($sformatf("%s.nrdy", tag), 32'(op_ready), 32'd0);
        op_valid = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h12345678; op_rd = ~rd; op_funct = 3'd0;
        while (!res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("%s.lat", tag), 32'(lat), 32'(exp_lat));
        chk($sformatf("%s.data", tag), res_data, exp);
        chk($sformatf("%s.rd", tag), 32'(res_rd), 32'(rd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk($sformatf("%s.hv", tag), 32'(res_valid), 32'd1);
            chk($sformatf("%s.hd", tag), res_data, exp);
            chk($sformatf("%s.hr", tag), 32'(op_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk($sformatf("%s.idlev", tag), 32'(res_valid), 32'd0);
        chk($sformatf("%s.idler", tag), 32'(op_ready), 32'd1);
    endtask

    initial begin
        int cnt;
        rst = 1'b0; flush = 1'b0; op_valid = 1'b0; op_funct = '0;
        op_a = '0; op_b = '0; op_rd = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(res_valid), 32'd0);
        chk("rst.data", res_data, 32'd0);
        chk("rst.rd", 32'(res_rd), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst.rdy", 32'(op_ready), 32'd1);

        run_op("mul",    3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 2, 0);
        run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, 2, 0);
        run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, 2, 0);
        run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 2, 0);
        run_op("div",    3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd7,  32'hFFFFFFFD, 34, 0);
        run_op("rem",    3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd8,  32'hFFFFFFFF, 34, 0);
        run_op("divu",   3'd5, 32'd100,      32'd7,        5'd9,  32'd14,       34, 0);
        run_op("remu",   3'd7, 32'd100,      32'd7,        5'd10, 32'd2,        34, 5);
        run_op("divu_big", 3'd5, 32'hFFFFFFFF, 32'h10,     5'd11, 32'h0FFFFFFF, 34, 0);
        run_op("remu_big", 3'd7, 32'hFFFFFFFF, 32'h10,     5'd12, 32'h0000000F, 34, 0);
        run_op("div0",   3'd4, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1, 0);
        run_op("rem0",   3'd6, 32'd5,        32'd0,        5'd14, 32'd5,        1, 0);
        run_op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, 0);
        run_op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1, 3);
`ifdef MULDIV_DIV_EARLY_OUT_EN
        run_op("rem_small", 3'd6, 32'hFFFFFFFB, 32'd7, 5'd17, 32'hFFFFFFFB, 1, 0);
        run_op("div_small", 3'd4, 32'hFFFFFFFB, 32'd7, 5'd18, 32'd0,        1, 0);
`else
        run_op("rem_small", 3'd6, 32'hFFFFFFFB, 32'd7, 5'd17, 32'hFFFFFFFB, 34, 0);
        run_op("div_small", 3'd4, 32'hFFFFFFFB, 32'd7, 5'd18, 32'd0,        34, 0);
`endif

        // flush a divide at T+10, then a MUL must still work
        op_valid = 1'b1; op_funct = 3'd4; op_a = 32'hFFFFFFF9; op_b = 32'd2; op_rd = 5'd19;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl.rdy", 32'(op_ready), 32'd0);
        chk("fl.busy", 32'(busy), 32'd1);
        @(negedge clk);
        op_valid = 1'b1; op_funct = 3'd0;
        #1;
        chk("fl.idle", 32'(busy), 32'd0);
        chk("fl.novalid", 32'(res_valid), 32'd0);
        chk("fl.blkrdy", 32'(op_ready), 32'd0);
        chk("fl.blksel", 32'(mul_sel), 32'd0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        chk("fl.noacc", 32'(busy), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("fl.nopulse", 32'(cnt), 32'd0);
        run_op("mul2", 3'd0, 32'h00000007, 32'hFFFFFFFD, 5'd20, 32'hFFFFFFEB, 2, 0);

        // asynchronous reset in the middle of a divide
        op_valid = 1'b1; op_funct = 3'd5; op_a = 32'd100; op_b = 32'd7; op_rd = 5'd21;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar.busy", 32'(busy), 32'd0);
        chk("ar.valid", 32'(res_valid), 32'd0);
        chk("ar.data", res_data, 32'd0);
        chk("ar.rd", 32'(res_rd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ar.rdy", 32'(op_ready), 32'd1);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        chk("ar.nopulse", 32'(cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
